memcpy_line_scheduler: RTL and testbench

Sequences a multi-line memory copy over split read/write request channels, replacing one-line-at-a-time read→write→ack stepping with a pipelined scheduler. Accepts one job (source line address, destination line address, line count). Keeps up to MAX_OUTSTANDING reads in flight, buffers returned lines in a small FIFO, and issues writes from that FIFO. Reports completion once every write is acknowledged. Sits between the MMIO CSR block (job source) and the CCI-P c0/c1 request shims.

---
 rtl/memcpy_line_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_memcpy_line_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memcpy_line_scheduler.sv
// rtl/memcpy_line_scheduler.sv - pipelined multi-line copy scheduler over split read/write channels
// Optional MEMCPY_SCHED_PERF_EN adds the perf_cycles busy-cycle counter output.
module memcpy_line_scheduler #(
  parameter int ADDR_W          = 42,
  parameter int LEN_W           = 17,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_src,
  input  logic [ADDR_W-1:0] job_dst,
  input  logic [LEN_W-1:0]  job_len,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [LEN_W-1:0]  rd_req_tag,
  input  logic              rd_almfull,
  input  logic              rd_rsp_valid,
  input  logic [LEN_W-1:0]  rd_rsp_tag,
  input  logic [DATA_W-1:0] rd_rsp_data,
  output logic              wr_req_valid,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [DATA_W-1:0] wr_req_data,
  input  logic              wr_almfull,
  input  logic              wr_rsp_valid,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  lines_acked
`ifdef MEMCPY_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [LEN_W-1:0] MAX_OS = LEN_W'(MAX_OUTSTANDING);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              r_state;
  logic [ADDR_W-1:0]       r_src;
  logic [ADDR_W-1:0]       r_dst;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_issued;
  logic [LEN_W-1:0]        r_written;
  logic [LEN_W-1:0]        r_acked;
  logic                    r_done;
  logic                    r_rd_valid;
  logic [ADDR_W-1:0]       r_rd_addr;
  logic [LEN_W-1:0]        r_rd_tag;
  logic                    r_wr_valid;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic [DATA_W-1:0]       r_wr_data;

  // Line buffer holds {tag, data}; the extra pointer bit separates full from empty.
  logic [LEN_W+DATA_W-1:0] r_mem [MAX_OUTSTANDING];
  logic [PW:0]             r_wptr;
  logic [PW:0]             r_rptr;

  logic                    w_busy;
  logic                    w_active;
  logic                    w_fifo_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_rd_fire;
  logic [LEN_W-1:0]        w_in_flight;
  logic [LEN_W+DATA_W-1:0] w_head;
  logic [LEN_W-1:0]        w_head_tag;
  logic [DATA_W-1:0]       w_head_data;

  assign w_busy       = (r_state != S_IDLE);
  assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_fifo_empty = (r_wptr == r_rptr);
  assign w_push       = w_busy && rd_rsp_valid;
  assign w_pop        = w_active && !w_fifo_empty && !wr_almfull;
  assign w_in_flight  = r_issued - r_written;
  // Credit: lines read but not yet written never exceed the buffer depth.
  assign w_rd_fire    = (r_state == S_RUN) && (r_issued < r_len) && !rd_almfull &&
                        (w_in_flight < MAX_OS);
  assign w_head       = r_mem[r_rptr[PW-1:0]];
  assign w_head_tag   = w_head[LEN_W+DATA_W-1:DATA_W];
  assign w_head_data  = w_head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PW-1:0]] <= {rd_rsp_tag, rd_rsp_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_written  <= '0;
      r_acked    <= '0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_tag   <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_rd_valid <= w_rd_fire;
      r_wr_valid <= w_pop;
      r_done     <= (r_state == S_DONE);

      if (w_rd_fire) begin
        r_rd_addr <= r_src + ADDR_W'(r_issued);
        r_rd_tag  <= r_issued;
        r_issued  <= r_issued + LEN_W'(1);
      end

      if (w_push) begin
        r_wptr <= r_wptr + (PW+1)'(1);
      end

      if (w_pop) begin
        r_rptr    <= r_rptr + (PW+1)'(1);
        r_wr_addr <= r_dst + ADDR_W'(w_head_tag);
        r_wr_data <= w_head_data;
        r_written <= r_written + LEN_W'(1);
      end

      if (w_active && wr_rsp_valid) begin
        r_acked <= r_acked + LEN_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_src     <= job_src;
            r_dst     <= job_dst;
            r_len     <= job_len;
            r_issued  <= '0;
            r_written <= '0;
            r_acked   <= '0;
            r_state   <= (job_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (r_issued == r_len) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_acked == r_len) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEMCPY_SCHED_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else if ((r_state == S_IDLE) && job_valid) begin
      r_perf <= '0;
    end else if (w_busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

  assign job_ready    = (r_state == S_IDLE);
  assign busy         = w_busy;
  assign done         = r_done;
  assign lines_acked  = r_acked;
  assign rd_req_valid = r_rd_valid;
  assign rd_req_addr  = r_rd_addr;
  assign rd_req_tag   = r_rd_tag;
  assign wr_req_valid = r_wr_valid;
  assign wr_req_addr  = r_wr_addr;
  assign wr_req_data  = r_wr_data;

endmodule

// File: tb/tb_memcpy_line_scheduler.sv
// tb/tb_memcpy_line_scheduler.sv - scoreboard bench for memcpy_line_scheduler
module tb_memcpy_line_scheduler;

  localparam int AW = 42;
  localparam int LW = 17;
  localparam int DW = 512;
  localparam int MO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  logic [AW-1:0] job_src;
  logic [AW-1:0] job_dst;
  logic [LW-1:0] job_len;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic [LW-1:0] rd_req_tag;
  logic          rd_almfull;
  logic          rd_rsp_valid;
  logic [LW-1:0] rd_rsp_tag;
  logic [DW-1:0] rd_rsp_data;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          wr_almfull;
  logic          wr_rsp_valid;
  logic          busy;
  logic          done;
  logic [LW-1:0] lines_acked;
`ifdef MEMCPY_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  memcpy_line_scheduler #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_src(job_src), .job_dst(job_dst), .job_len(job_len),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
    .rd_almfull(rd_almfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tag(rd_rsp_tag), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_almfull(wr_almfull), .wr_rsp_valid(wr_rsp_valid),
    .busy(busy), .done(done), .lines_acked(lines_acked)
`ifdef MEMCPY_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Job context shared by the stimulus, responder and monitor processes.
  logic [AW-1:0] job_src_b;
  logic [AW-1:0] job_dst_b;
  int            job_len_b = 0;
  logic [DW-1:0] exp_data [64];
  int            rd_seen = 0, rd_base = 0;
  int            wr_seen = 0, wr_base = 0;
  int            done_cnt = 0, done_base = 0, done_cyc = 0, acc_cyc = 0;
  int            rsp_mode = 1;  // 0 random order, 1 withhold, 2 scripted order, 3 late (no expectation)
  int            order_q[$];
  int            pending[$];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  bit            rd_alm_rand = 0, wr_alm_rand = 0, wr_alm_force = 0;

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Read-side memory model: checks each read request, returns lines and records the expected write.
  initial begin
    int idx, k, t;
    bit send, exp_w;
    rd_rsp_valid = 1'b0; rd_rsp_tag = '0; rd_rsp_data = '0;
    rd_almfull = 1'b0; wr_almfull = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_req_valid) begin
        idx = rd_seen - rd_base;
        check(idx < job_len_b, "rd_extra", idx, job_len_b);
        check(rd_req_addr == job_src_b + AW'(idx), "rd_addr", rd_req_addr, job_src_b + AW'(idx));
        check(rd_req_tag == LW'(idx), "rd_tag", rd_req_tag, idx);
        if (idx < 64) pending.push_back(idx);
        rd_seen++;
      end
      send = 0; exp_w = 0; t = 0;
      if (rsp_mode == 0 && pending.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, pending.size() - 1);
        t = pending[k]; pending.delete(k); send = 1; exp_w = 1;
      end else if (rsp_mode == 2 && order_q.size() > 0) begin
        t = order_q.pop_front();
        for (int j = 0; j < pending.size(); j++) begin
          if (pending[j] == t) begin pending.delete(j); break; end
        end
        send = 1; exp_w = 1;
      end else if (rsp_mode == 3 && pending.size() > 0) begin
        t = pending.pop_front(); send = 1;
      end
      rd_rsp_valid = send;
      rd_rsp_tag   = LW'(t);
      rd_rsp_data  = exp_data[t];
      if (exp_w) begin
        exp_wa.push_back(job_dst_b + AW'(t));
        exp_wd.push_back(exp_data[t]);
      end
      rd_almfull = rd_alm_rand && ($urandom_range(0, 3) == 0);
      wr_almfull = wr_alm_force || (wr_alm_rand && ($urandom_range(0, 3) == 0));
    end
  end

  // Write-side monitor: pops the scoreboard on every write, acks writes later, counts done pulses.
  initial begin
    int ack_pend;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ack_pend = 0;
    wr_rsp_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req_valid) begin
        if (exp_wa.size() == 0) begin
          check(1'b0, "wr_unexpected", wr_req_addr, 0);
        end else begin
          ea = exp_wa.pop_front();
          ed = exp_wd.pop_front();
          check(wr_req_addr == ea, "wr_addr", wr_req_addr, ea);
          check(wr_req_data == ed, "wr_data", wr_req_data, ed);
        end
        wr_seen++;
        ack_pend++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      wr_rsp_valid = 1'b0;
      if (ack_pend > 0 && $urandom_range(0, 2) != 0) begin
        wr_rsp_valid = 1'b1;
        ack_pend--;
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input int mode);
    int w;
    w = 0;
    while (!job_ready && w < 500) begin @(negedge clk); w++; end
    check(job_ready, "job_ready_wait", job_ready, 1);
    for (int i = 0; i < n && i < 64; i++) exp_data[i] = rand_line();
    job_src_b = s; job_dst_b = d; job_len_b = n;
    rsp_mode  = mode;
    rd_base   = rd_seen; wr_base = wr_seen; done_base = done_cnt;
    job_src = s; job_dst = d; job_len = LW'(n);
    job_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    job_valid = 1'b0;
    job_src = AW'({$urandom, $urandom}); job_len = LW'($urandom);
  endtask

  task automatic finish_job();
    int w;
    w = 0;
    while (done_cnt == done_base && w < 3000) begin @(negedge clk); w++; end
    check(done_cnt != done_base, "done_timeout", w, 3000);
    repeat (3) @(negedge clk);
    check(done_cnt == done_base + 1, "done_pulses", done_cnt - done_base, 1);
    check(lines_acked == LW'(job_len_b), "lines_acked", lines_acked, job_len_b);
    check(wr_seen - wr_base == job_len_b, "wr_total", wr_seen - wr_base, job_len_b);
    check(rd_seen - rd_base == job_len_b, "rd_total", rd_seen - rd_base, job_len_b);
    check(exp_wa.size() == 0, "wr_missing", exp_wa.size(), 0);
    check(!busy && job_ready, "idle_after_done", {busy, job_ready}, 2'b01);
  endtask

  initial begin
    int w, viol, n;
    logic [AW-1:0] s, d;
    reset = 1'b1; job_valid = 1'b0; job_src = '0; job_dst = '0; job_len = '0;
    repeat (4) @(negedge clk);
    check(job_ready == 1'b1, "rst_job_ready", job_ready, 1);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(done == 1'b0, "rst_done", done, 0);
    check(lines_acked == '0, "rst_lines_acked", lines_acked, 0);
    check(!rd_req_valid && !wr_req_valid, "rst_req_valid", {rd_req_valid, wr_req_valid}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 4-line copy with random response order.
    start_job(42'h1000, 42'h2000, 4, 0);
    check(busy == 1'b1, "busy_in_job", busy, 1);
    finish_job();

    // Credit limit: only MO reads while responses are withheld.
    start_job(42'h5000, 42'h9000, 20, 1);
    repeat (30) @(negedge clk);
    check(rd_seen - rd_base == MO, "credit_limit", rd_seen - rd_base, MO);
    rsp_mode = 0;
    finish_job();

    // Scripted out-of-order responses 3,1,0,2.
    start_job(42'h300, 42'h700, 4, 1);
    w = 0;
    while (rd_seen - rd_base < 4 && w < 100) begin @(negedge clk); w++; end
    check(rd_seen - rd_base == 4, "ooo_reads", rd_seen - rd_base, 4);
    order_q = '{3, 1, 0, 2};
    rsp_mode = 2;
    finish_job();

    // Write channel held almost-full mid-job.
    start_job(42'h10000, 42'h20000, 30, 0);
    w = 0;
    while (wr_seen - wr_base < 5 && w < 500) begin @(negedge clk); w++; end
    wr_alm_force = 1'b1;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0 && wr_req_valid) viol++;
    end
    wr_alm_force = 1'b0;
    check(viol == 0, "wr_almfull_hold", viol, 0);
    finish_job();

    // Zero-length job: no traffic, done two cycles after accept.
    start_job(42'h123, 42'h456, 0, 0);
    finish_job();
    check(done_cyc == acc_cyc + 2, "len0_done_latency", done_cyc - acc_cyc, 2);

    // Reset mid-job, then late responses must be dropped.
    start_job(42'hA000, 42'hB000, 10, 1);
    w = 0;
    while (rd_seen - rd_base < 3 && w < 100) begin @(negedge clk); w++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_mode = 3;
    repeat (15) @(negedge clk);
    check(busy == 1'b0 && job_ready == 1'b1, "post_reset_idle", {busy, job_ready}, 2'b01);
    check(lines_acked == '0, "post_reset_acked", lines_acked, 0);
    check(wr_seen == wr_base, "post_reset_no_wr", wr_seen - wr_base, 0);
    start_job(42'hC000, 42'hD000, 2, 0);
    finish_job();

    // Random jobs with random back-pressure, including address wrap.
    rd_alm_rand = 1'b1;
    wr_alm_rand = 1'b1;
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 40);
      s = AW'({$urandom, $urandom});
      d = AW'({$urandom, $urandom});
      if (j == 0) s = {AW{1'b1}} - AW'(2);
      if (j == 1) d = {AW{1'b1}} - AW'(5);
      start_job(s, d, n, 0);
      finish_job();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
